cpu_control_unit: RTL and testbench



---
 rtl/cpu_control_unit.sv | 195 +++++++++++++++++++
 tb/tb_cpu_control_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute/writeback sequencer for
// the 8-bit CPU. It owns the program counter and the instruction register. It
// drives the register file selects and write strobe, plus the ALU op code and
// the immediate value.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When defined, an illegal opcode
// sets a sticky illegal_op flag and halts the core. When undefined, an illegal
// opcode executes as a NOP.
module cpu_control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic        instr_req,
    output logic [7:0]  instr_addr,
    input  logic        instr_valid,
    input  logic [15:0] instr_data,
    input  logic        alu_zero,
    output logic [2:0]  Register_Destination,
    output logic [2:0]  Register_1_operand,
    output logic [2:0]  Register_2_operand,
    output logic        RegWrite,
    output logic [2:0]  alu_op,
    output logic        imm_sel,
    output logic [7:0]  imm_value,
    output logic        halted,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;
    logic [7:0]  pc;
    logic [7:0]  pc_next;
    logic        z_flag;
    logic [3:0]  opcode;
    logic        is_alu;
    logic        writes_reg;
    logic        updates_z;

    // Opcode classes. Everything is decoded from the instruction register,
    // which changes only on a FETCH handshake. This keeps the selects stable
    // from DECODE through WRITEBACK.
    assign opcode     = ir[15:12];
    assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_XOR);
    assign writes_reg = (opcode >= OP_ADD) && (opcode <= OP_MOV);
    assign updates_z  = is_alu || (opcode == OP_MOV);

    assign instr_addr           = pc;
    assign Register_Destination = ir[11:9];
    assign Register_1_operand   = ir[8:6];
    assign Register_2_operand   = ir[5:3];
    assign imm_value            = ir[7:0];
    assign imm_sel              = (opcode == OP_LDI);

    // ALU function select: register ops map to 0..4, and MOV passes operand A.
    always_comb begin
        alu_op = 3'd0;
        case (opcode)
            OP_ADD:  alu_op = 3'd0;
            OP_SUB:  alu_op = 3'd1;
            OP_AND:  alu_op = 3'd2;
            OP_OR:   alu_op = 3'd3;
            OP_XOR:  alu_op = 3'd4;
            OP_MOV:  alu_op = 3'd5;
            default: alu_op = 3'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register. It captures the memory word only on a FETCH
    // handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir <= 16'h0000;
        end else if ((state == S_FETCH) && instr_valid) begin
            ir <= instr_data;
        end
    end

    // Next-PC selection. Jumps load the immediate. Everything else steps by
    // one, and the 8-bit add wraps FF to 00.
    always_comb begin
        pc_next = pc + 8'd1;
        if (opcode == OP_JMP) begin
            pc_next = ir[7:0];
        end else if ((opcode == OP_JZ) && z_flag) begin
            pc_next = ir[7:0];
        end
    end

    // Program counter. It advances only on the WRITEBACK edge, so instr_addr
    // holds for the whole instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (state == S_WRITEBACK) begin
            pc <= pc_next;
        end
    end

    // Zero flag. It latches the ALU result in EXECUTE for register ops and
    // MOV only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_flag <= 1'b0;
        end else if ((state == S_EXECUTE) && updates_z) begin
            z_flag <= alu_zero;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic is_illegal;
    logic illegal_q;

    assign is_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);
    assign illegal_op = illegal_q;

    // Sticky trap flag. It is set when DECODE sees an opcode in A..E.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if ((state == S_DECODE) && is_illegal) begin
            illegal_q <= 1'b1;
        end
    end
`else
    assign illegal_op = 1'b0;
`endif

    // Sequencing and strobes. RegWrite is combinational from the state, so an
    // asynchronous reset in WRITEBACK cancels the write at once.
    always_comb begin
        state_next = state;
        instr_req  = 1'b0;
        RegWrite   = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_next = is_illegal ? S_HALT : S_EXECUTE;
`else
                state_next = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                RegWrite   = writes_reg;
                state_next = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed self-checking bench for cpu_control_unit.
// The expected values are hand-computed from the instruction encodings.
module tb_cpu_control_unit;

    logic        clk;
    logic        rst;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic        alu_zero;
    logic [2:0]  Register_Destination;
    logic [2:0]  Register_1_operand;
    logic [2:0]  Register_2_operand;
    logic        RegWrite;
    logic [2:0]  alu_op;
    logic        imm_sel;
    logic [7:0]  imm_value;
    logic        halted;
    logic        illegal_op;

    int compare_count;
    int mismatch_count;

    logic [2:0] wb_dest;
    logic [2:0] wb_rs1;
    logic [2:0] wb_rs2;
    logic [2:0] wb_alu_op;
    logic       wb_imm_sel;
    logic [7:0] wb_imm;
    logic       wb_we;

    cpu_control_unit #(.RESET_PC(8'h00)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instr_req            (instr_req),
        .instr_addr           (instr_addr),
        .instr_valid          (instr_valid),
        .instr_data           (instr_data),
        .alu_zero             (alu_zero),
        .Register_Destination (Register_Destination),
        .Register_1_operand   (Register_1_operand),
        .Register_2_operand   (Register_2_operand),
        .RegWrite             (RegWrite),
        .alu_op               (alu_op),
        .imm_sel              (imm_sel),
        .imm_value            (imm_value),
        .halted               (halted),
        .illegal_op           (illegal_op)
    );

    // 100 MHz free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequencer wedges somewhere.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full instruction, starting anywhere inside a FETCH cycle. It holds
    // instr_valid low for wait_cycles, then hands over the word. Garbage is
    // presented with valid high during DECODE/EXECUTE. The WRITEBACK view is
    // captured, and the bench ends #1 after the edge that leaves WRITEBACK.
    task automatic applyStimulus(input string tag, input logic [15:0] word, input int wait_cycles,
                                 input logic zero_in, input int exp_we, input logic [7:0] exp_addr);
        logic [7:0] start_addr;
        int we_count;
        int hold_err;
        int addr_err;
        start_addr  = instr_addr;
        we_count    = 0;
        hold_err    = 0;
        addr_err    = 0;
        alu_zero    = zero_in;
        instr_valid = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            @(posedge clk); #1;
            if (!instr_req || RegWrite || halted) hold_err++;
            if (instr_addr != start_addr) addr_err++;
        end
        instr_valid = 1'b1;
        instr_data  = word;
        @(posedge clk); #1;
        instr_data  = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            if (RegWrite) we_count++;
            if (instr_addr != start_addr) addr_err++;
            if (c == 2) begin
                wb_dest     = Register_Destination;
                wb_rs1      = Register_1_operand;
                wb_rs2      = Register_2_operand;
                wb_alu_op   = alu_op;
                wb_imm_sel  = imm_sel;
                wb_imm      = imm_value;
                wb_we       = RegWrite;
                instr_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        checkOutput({tag, "_we_count"}, we_count, exp_we);
        checkOutput({tag, "_addr_hold"}, addr_err, 0);
        checkOutput({tag, "_next_addr"}, instr_addr, exp_addr);
        if (wait_cycles > 0) checkOutput({tag, "_wait_hold"}, hold_err, 0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        instr_valid    = 1'b0;
        instr_data     = 16'h0000;
        alu_zero       = 1'b0;
        doReset();

        // Reset state.
        checkOutput("rst_req", instr_req, 1);
        checkOutput("rst_addr", instr_addr, 8'h00);
        checkOutput("rst_we", RegWrite, 0);
        checkOutput("rst_dest", Register_Destination, 0);
        checkOutput("rst_rs1", Register_1_operand, 0);
        checkOutput("rst_rs2", Register_2_operand, 0);
        checkOutput("rst_alu_op", alu_op, 0);
        checkOutput("rst_imm_sel", imm_sel, 0);
        checkOutput("rst_imm", imm_value, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_illegal", illegal_op, 0);

        // LDI r0,0xAA at PC 0.
        applyStimulus("ldi", 16'h60AA, 0, 1'b0, 1, 8'h01);
        checkOutput("ldi_wb_we", wb_we, 1);
        checkOutput("ldi_dest", wb_dest, 0);
        checkOutput("ldi_imm_sel", wb_imm_sel, 1);
        checkOutput("ldi_imm", wb_imm, 8'hAA);

        // ADD r7,r0,r1.
        applyStimulus("add", 16'h1E08, 0, 1'b0, 1, 8'h02);
        checkOutput("add_rs1", wb_rs1, 0);
        checkOutput("add_rs2", wb_rs2, 1);
        checkOutput("add_alu_op", wb_alu_op, 0);
        checkOutput("add_dest", wb_dest, 7);
        checkOutput("add_imm_sel", wb_imm_sel, 0);

        // SUB r1,r2,r3 with a zero result latches Z.
        applyStimulus("sub", 16'h2298, 0, 1'b1, 1, 8'h03);
        checkOutput("sub_alu_op", wb_alu_op, 1);

        // JZ 0x40 taken. A low alu_zero during JZ must not touch Z.
        applyStimulus("jz_taken", 16'h9040, 0, 1'b0, 0, 8'h40);

        // MOV r2,r5 clears Z.
        applyStimulus("mov", 16'h7540, 0, 1'b0, 1, 8'h41);
        checkOutput("mov_alu_op", wb_alu_op, 5);
        checkOutput("mov_dest", wb_dest, 2);
        checkOutput("mov_rs1", wb_rs1, 5);

        // JZ 0x40 not taken. A high alu_zero during JZ must not set Z.
        applyStimulus("jz_not", 16'h9040, 0, 1'b1, 0, 8'h42);

        // JMP to FF, JMP from FF, then a NOP at FF wraps to 00.
        applyStimulus("jmp_ff", 16'h80FF, 0, 1'b0, 0, 8'hFF);
        applyStimulus("jmp_from_ff", 16'h8010, 0, 1'b0, 0, 8'h10);
        applyStimulus("jmp_ff2", 16'h80FF, 0, 1'b0, 0, 8'hFF);
        applyStimulus("nop_wrap", 16'h0000, 0, 1'b0, 0, 8'h00);

        // AND r3,r4,r5 with five cycles of memory wait.
        applyStimulus("and_wait", 16'h3728, 5, 1'b0, 1, 8'h01);
        checkOutput("and_alu_op", wb_alu_op, 2);

        // XOR r1,r1,r1.
        applyStimulus("xor", 16'h5248, 0, 1'b0, 1, 8'h02);
        checkOutput("xor_alu_op", wb_alu_op, 4);

        // Illegal opcode 0xB.
`ifdef CTRL_ILLEGAL_TRAP_EN
        applyStimulus("illegal", 16'hB123, 0, 1'b0, 0, 8'h02);
        checkOutput("illegal_flag", illegal_op, 1);
        checkOutput("illegal_halted", halted, 1);
        checkOutput("illegal_req", instr_req, 0);
`else
        applyStimulus("illegal", 16'hB123, 0, 1'b0, 0, 8'h03);
        checkOutput("illegal_flag", illegal_op, 0);
        checkOutput("illegal_halted", halted, 0);
        checkOutput("illegal_req", instr_req, 1);
`endif
        doReset();
        checkOutput("rst2_illegal", illegal_op, 0);
        checkOutput("rst2_addr", instr_addr, 8'h00);

        // Reset during the WRITEBACK of an ADD at PC 1.
        applyStimulus("ldi_r1", 16'h6205, 0, 1'b0, 1, 8'h01);
        instr_valid = 1'b1;
        instr_data  = 16'h1E08;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midrst_pre_we", RegWrite, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_we_drop", RegWrite, 0);
        checkOutput("midrst_addr", instr_addr, 8'h00);
        checkOutput("midrst_req", instr_req, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("midrst_fetch_req", instr_req, 1);
        checkOutput("midrst_fetch_addr", instr_addr, 8'h00);
        applyStimulus("nop_after_rst", 16'h0000, 0, 1'b0, 0, 8'h01);

        // HALT stays halted with valid traffic until reset.
        applyStimulus("halt", 16'hF000, 0, 1'b0, 0, 8'h02);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_req", instr_req, 0);
        begin
            int bad;
            bad = 0;
            instr_valid = 1'b1;
            instr_data  = 16'h60AA;
            repeat (4) begin
                @(posedge clk); #1;
                if (RegWrite || instr_req || !halted || instr_addr != 8'h02) bad++;
            end
            instr_valid = 1'b0;
            checkOutput("halt_stuck", bad, 0);
        end
        doReset();
        checkOutput("rst3_halted", halted, 0);
        checkOutput("rst3_req", instr_req, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
